fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/quesadilla_pkg.sv | 20 ++
 rtl/fetch_pc_reg.sv | 46 ++++
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/quesadilla_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// quesadilla_pkg : shared types and constants for the instruction fetch path
// Rev 1.0
// ----------------------------------------------------------------------------
package quesadilla_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_INCR = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_pc_reg : program counter with redirect-over-increment next-value mux
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_pc_reg
    import quesadilla_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic              incr_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_next_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // A redirect wins over the sequential step; targets are word aligned.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i & ~ADDR_W'(3);
        end else if (incr_i) begin
            pc_d = pc_q + ADDR_W'(PC_INCR);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign pc_next_o = pc_d;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_sequencer : single-outstanding instruction fetch FSM with redirect
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_sequencer
    import quesadilla_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [31:0]        fetch_count
);

    state_e             state_q;
    logic               mem_req_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic               instr_valid_q;
    logic [INSTR_W-1:0] instr_data_q;
    logic [ADDR_W-1:0]  instr_pc_q;
    logic [31:0]        fetch_count_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic               handoff;

    assign handoff = (state_q == ST_HOLD) && instr_valid_q && instr_ready;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load_i    (redirect_valid),
        .target_i  (redirect_pc),
        .incr_i    (handoff),
        .pc_o      (pc_q),
        .pc_next_o (pc_d)
    );

    // The read strobe is registered on the transition into FETCH, so it is
    // visible for exactly the cycle the FSM sits in FETCH, addressed by pc_d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_pc_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            mem_req_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    mem_req_q  <= 1'b1;
                    mem_addr_q <= pc_d;
                    state_q    <= ST_FETCH;
                end
                ST_FETCH: begin
                    state_q <= redirect_valid ? ST_DRAIN : ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_rvalid && !redirect_valid) begin
                        instr_data_q  <= mem_rdata;
                        instr_pc_q    <= pc_q;
                        instr_valid_q <= 1'b1;
                        state_q       <= ST_HOLD;
                    end else if (mem_rvalid) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_d;
                        state_q    <= ST_FETCH;
                    end else if (redirect_valid) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_HOLD: begin
                    if (handoff) begin
                        fetch_count_q <= fetch_count_q + 32'd1;
                    end
                    if (handoff || redirect_valid) begin
                        instr_valid_q <= 1'b0;
                        mem_req_q     <= 1'b1;
                        mem_addr_q    <= pc_d;
                        state_q       <= ST_FETCH;
                    end
                end
                // The stale response is dropped here; only then may a new read go out.
                ST_DRAIN: begin
                    if (mem_rvalid) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_d;
                        state_q    <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr_data  = instr_data_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_count = fetch_count_q;

endmodule
`default_nettype wire
